clkdiv_ctrl: RTL and testbench
==============================

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 SHALL have parameter NSM, default 4, meaning number of state-machine clock-enable channels (1..4).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_en  input  1  divider configuration write strobe, one write per asserted cycle.
REQ-005 SHALL have port wr_sm  input  2  target channel index for the write; indices >= NSM are ignored.
REQ-006 SHALL have port wr_div  input  24  new divider: [23:8] integer INT, [7:0] fraction FRAC (1/256 units).
REQ-007 SHALL have port en  input  NSM  per-channel run enable, level-sensitive.
REQ-008 SHALL have port restart  input  NSM  per-channel phase restart, one-cycle pulse.
REQ-009 SHALL have port pen  output  NSM  per-channel registered clock-enable pulse, one cycle wide.
REQ-010 SHALL have port upd_pending  output  NSM  per-channel flag: shadow divider written but not yet active.

Function
REQ-011 SHALL hold per channel: active divider act[23:0], shadow divider shd[23:0], down-counter cnt[16:0], fraction accumulator facc[7:0].
REQ-012 SHALL define INT_eff = 65536 when act[23:8]==0, else act[23:8] (17-bit arithmetic, no truncation).
REQ-013 SHALL, when en[i]=1 and cnt[i]==0 in cycle t, assert pen[i]=1 in cycle t+1 (a "reload" event).
REQ-014 SHALL, on reload, compute sum = facc + act[7:0] (9-bit); carry = sum[8]; facc <= sum[7:0]; cnt <= INT_eff + carry - 1.
REQ-015 SHALL, when en[i]=1 and cnt[i]!=0, decrement cnt[i] by 1 and drive pen[i]=0 next cycle.
REQ-016 SHALL, when en[i]=0, hold cnt and facc unchanged and drive pen[i]=0 next cycle.
REQ-017 SHALL produce an average period of INT+FRAC/256 cycles; consecutive pen pulse spacing is INT or INT+1 cycles.
REQ-018 SHALL, for div 1.0 (INT=1, FRAC=0), assert pen[i] every cycle while en[i]=1.
REQ-019 SHALL, on wr_en with valid wr_sm, load shd[wr_sm] <= wr_div and set upd_pending[wr_sm]=1 next cycle.
REQ-020 SHALL copy shd into act and clear upd_pending at the first of: a reload event, a restart pulse, or any cycle with en[i]=0 and pending set.
REQ-021 SHALL, when a reload and a write to the same channel occur in one cycle, compute the reload with the pre-existing act, store the write in shd, and leave upd_pending=1.
REQ-022 SHALL, when a pending shadow is applied on a reload, use the newly applied divider for that reload's INT_eff/FRAC computation.
REQ-023 SHALL, on restart[i], force cnt[i] <= 0 and facc[i] <= 0, overriding any same-cycle reload or decrement; pen[i]=0 next cycle.
REQ-024 SHALL phase-align channels restarted in the same cycle with identical act and en: their pen pulses coincide thereafter.
REQ-025 SHALL give each channel fully independent behaviour; no channel's inputs affect another's outputs.

Reset
REQ-026 SHALL, while reset=1, set act=shd=24'h000100, cnt=0, facc=0, pen=0, upd_pending=0 on every channel, overriding all other inputs.
REQ-027 SHALL, with reset released and en[i]=1 in first cycle, assert pen[i] in the next cycle (div 1.0, every cycle).
REQ-028 SHALL discard any write, restart or pending update presented during a reset cycle.

Verification
REQ-029 SHALL pass: write ch0 div 24'h000300, pulse restart[0], en[0]=1 -> pen[0] pulses every 3 cycles, upd_pending[0] clears one cycle after restart.
REQ-030 SHALL pass: ch1 div 24'h000280 (2.5), enabled 20 cycles from restart -> pen spacing alternates 2,3,2,3...; 8 pulses in 20 cycles.
REQ-031 SHALL pass: ch2 div 24'h000000, enabled -> exactly one pen pulse per 65536 cycles.
REQ-032 SHALL pass: ch0 running div 4.0, write div 2.0 mid-period -> current period completes at 4 cycles, following periods are 2; write in reload cycle defers by one further period.
REQ-033 SHALL pass: ch0 div 3, ch1 div 3 out of phase, restart=4'b0011 -> pen[0] and pen[1] coincide on every subsequent pulse.
REQ-034 SHALL pass: en[0] dropped for 5 cycles mid-period then restored -> pulse delayed by exactly 5 cycles; reset asserted mid-run -> pen=0 next cycle, divider back to 1.0.

Source files
------------

// File: rtl/clkdiv_ctrl.sv
// Fractional clock-enable generator: NSM independent channels, each emitting a
// one-cycle pen pulse with an average period of INT + FRAC/256 clock cycles.
module clkdiv_ctrl #(
  parameter int NSM = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [1:0]     wr_sm,
  input  logic [23:0]    wr_div,
  input  logic [NSM-1:0] en,
  input  logic [NSM-1:0] restart,
  output logic [NSM-1:0] pen,
  output logic [NSM-1:0] upd_pending
);

  localparam logic [23:0] DivReset = 24'h000100;

  for (genvar i = 0; i < NSM; i++) begin : gChan
    logic [23:0] act_q, act_d;
    logic [23:0] shd_q, shd_d;
    logic [16:0] cnt_q, cnt_d;
    logic [7:0]  facc_q, facc_d;
    logic        pen_q, pen_d;
    logic        pend_q, pend_d;
    logic        wrHit, reloadHit, applyShd;
    logic [23:0] divUse;
    logic [16:0] intEff;
    logic [8:0]  fracSum;

    // A pending shadow is adopted before the reload math, so a reload that
    // applies it already runs with the new divider; a write landing in the
    // same cycle only refills the shadow and keeps the channel pending.
    always_comb begin
      wrHit     = wr_en && (wr_sm == 2'(i));
      reloadHit = en[i] && (cnt_q == 17'd0);
      applyShd  = pend_q && (reloadHit || restart[i] || !en[i]);
      divUse    = applyShd ? shd_q : act_q;
      intEff    = (divUse[23:8] == 16'd0) ? 17'h10000 : {1'b0, divUse[23:8]};
      fracSum   = {1'b0, facc_q} + {1'b0, divUse[7:0]};

      act_d  = divUse;
      shd_d  = wrHit ? wr_div : shd_q;
      pend_d = wrHit || (pend_q && !applyShd);
      cnt_d  = cnt_q;
      facc_d = facc_q;
      pen_d  = 1'b0;

      if (restart[i]) begin
        cnt_d  = '0;
        facc_d = '0;
      end else if (reloadHit) begin
        cnt_d  = intEff + {16'd0, fracSum[8]} - 17'd1;
        facc_d = fracSum[7:0];
        pen_d  = 1'b1;
      end else if (en[i]) begin
        cnt_d = cnt_q - 17'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        act_q  <= DivReset;
        shd_q  <= DivReset;
        cnt_q  <= '0;
        facc_q <= '0;
        pen_q  <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        act_q  <= act_d;
        shd_q  <= shd_d;
        cnt_q  <= cnt_d;
        facc_q <= facc_d;
        pen_q  <= pen_d;
        pend_q <= pend_d;
      end
    end

    assign pen[i]         = pen_q;
    assign upd_pending[i] = pend_q;
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: a phase-timeline reference model checked
// every cycle, plus directed scenarios with hand-computed pulse positions.
module tb_clkdiv_ctrl;

   localparam int NSM = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           wr_en;
   logic [1:0]     wr_sm;
   logic [23:0]    wr_div;
   logic [NSM-1:0] en;
   logic [NSM-1:0] restart;
   logic [NSM-1:0] pen;
   logic [NSM-1:0] upd_pending;

   int checks = 0;
   int errors = 0;

   clkdiv_ctrl #(.NSM(NSM)) dut (
      .clk(clk),
      .reset(reset),
      .wr_en(wr_en),
      .wr_sm(wr_sm),
      .wr_div(wr_div),
      .en(en),
      .restart(restart),
      .pen(pen),
      .upd_pending(upd_pending)
   );

   always #5 clk = ~clk;

   // Reference model: each channel walks a timeline of enabled cycles; pulse n
   // is due at enabled cycle floor(base/256), where base sums applied dividers
   // in 1/256-cycle units since the last restart or reset.
   logic [23:0]    mAct [NSM];
   logic [23:0]    mShd [NSM];
   longint         mIdx [NSM];
   longint         mBase[NSM];
   logic [NSM-1:0] expPen;
   logic [NSM-1:0] expPend;
   bit             modelLive = 1'b0;

   logic [NSM-1:0] capPen [64];
   logic [NSM-1:0] capPend[64];

   function automatic longint divUnits(input logic [23:0] d);
      longint intPart;
      intPart = (d[23:8] == 16'd0) ? 64'd65536 : longint'(d[23:8]);
      return intPart * 256 + longint'(d[7:0]);
   endfunction

   initial begin
      logic        hit, slot, apply;
      logic [23:0] useDiv;
      forever begin
         @(posedge clk);
         for (int c = 0; c < NSM; c++) begin
            if (reset) begin
               mAct[c]    = 24'h000100;
               mShd[c]    = 24'h000100;
               mIdx[c]    = 0;
               mBase[c]   = 0;
               expPen[c]  = 1'b0;
               expPend[c] = 1'b0;
            end else begin
               hit    = wr_en && (int'(wr_sm) == c);
               slot   = en[c] && (mIdx[c] == (mBase[c] >> 8));
               apply  = expPend[c] && (slot || restart[c] || !en[c]);
               useDiv = apply ? mShd[c] : mAct[c];
               if (restart[c]) begin
                  mIdx[c]   = 0;
                  mBase[c]  = 0;
                  expPen[c] = 1'b0;
               end else if (en[c]) begin
                  expPen[c] = slot;
                  if (slot) mBase[c] = mBase[c] + divUnits(useDiv);
                  mIdx[c] = mIdx[c] + 1;
               end else begin
                  expPen[c] = 1'b0;
               end
               mAct[c] = useDiv;
               if (hit) begin
                  mShd[c]    = wr_div;
                  expPend[c] = 1'b1;
               end else if (apply) begin
                  expPend[c] = 1'b0;
               end
            end
         end
         if (reset) modelLive = 1'b1;
      end
   end

   // Every cycle once the model has seen reset, outputs must match it exactly.
   initial begin
      forever begin
         @(negedge clk);
         if (modelLive) begin
            checks++;
            if (pen !== expPen || upd_pending !== expPend) begin
               errors++;
               $display("[TB] FAIL model t=%0t pen=%b want %b upd_pending=%b want %b",
                        $time, pen, expPen, upd_pending, expPend);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog expired at t=%0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Restart/enable as given, then capture n samples; optional writes after
   // samples wrAtA/wrAtB and an enable gap on offCh for samples [offFrom, offFrom+offLen).
   task automatic applyStimulus(input logic [NSM-1:0] rstMask, input logic [NSM-1:0] enMask,
                                input int n,
                                input int wrAtA, input logic [1:0] chA, input logic [23:0] divA,
                                input int wrAtB, input logic [1:0] chB, input logic [23:0] divB,
                                input int offCh, input int offFrom, input int offLen);
      restart = rstMask;
      en      = enMask;
      wr_en   = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         capPen[k]  = pen;
         capPend[k] = upd_pending;
         restart    = '0;
         wr_en      = 1'b0;
         if (k == wrAtA) begin wr_en = 1'b1; wr_sm = chA; wr_div = divA; end
         if (k == wrAtB) begin wr_en = 1'b1; wr_sm = chB; wr_div = divB; end
         en = enMask;
         if (k >= offFrom && k < offFrom + offLen) en[offCh] = 1'b0;
      end
   endtask

   task automatic writeDiv(input logic [1:0] ch, input logic [23:0] d);
      en     = '0;
      wr_en  = 1'b1;
      wr_sm  = ch;
      wr_div = d;
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   function automatic logic [63:0] bitsOf(input int ch, input int n, input bit fromPend);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v[k] = fromPend ? capPend[k][ch] : capPen[k][ch];
      return v;
   endfunction

   function automatic logic [63:0] at(input int p);
      return 64'd1 << p;
   endfunction

   initial begin
      int pulseCount;
      int secondAt;

      // Reset with a write and restarts presented, which must be discarded.
      reset = 1'b1; wr_en = 1'b1; wr_sm = 2'd0; wr_div = 24'h000500;
      restart = '1; en = '1;
      repeat (2) @(negedge clk);
      checkOutput("reset pen", 64'(pen), 64'h0);
      checkOutput("reset pending", 64'(upd_pending), 64'h0);
      reset = 1'b0; wr_en = 1'b0; restart = '0; en = '1;
      @(negedge clk);
      checkOutput("first pen after reset", 64'(pen), 64'hF);
      @(negedge clk);
      checkOutput("div 1.0 second cycle", 64'(pen), 64'hF);
      checkOutput("no pending after reset", 64'(upd_pending), 64'h0);

      // Divide by 3 on channel 0 after restart.
      en = '0; wr_en = 1'b1; wr_sm = 2'd0; wr_div = 24'h000300;
      @(negedge clk);
      wr_en = 1'b0;
      checkOutput("pending after write", 64'(upd_pending), 64'h1);
      applyStimulus(4'b0001, 4'b0001, 10, -1, 2'd0, 24'h0, -1, 2'd0, 24'h0, 0, 0, 0);
      checkOutput("div3 pulses", bitsOf(0, 10, 1'b0), at(1) | at(4) | at(7));
      checkOutput("div3 pending cleared", bitsOf(0, 10, 1'b1), 64'h0);

      // Divide by 2.5 on channel 1.
      writeDiv(2'd1, 24'h000280);
      applyStimulus(4'b0010, 4'b0010, 20, -1, 2'd0, 24'h0, -1, 2'd0, 24'h0, 0, 0, 0);
      checkOutput("div2.5 pulse count", 64'($countones(bitsOf(1, 20, 1'b0))), 64'd8);
      checkOutput("div2.5 pulses", bitsOf(1, 20, 1'b0),
                  at(1) | at(3) | at(6) | at(8) | at(11) | at(13) | at(16) | at(18));

      // 4.0 -> 2.0 mid-period, then 2.0 -> 4.0 written in a reload cycle.
      writeDiv(2'd0, 24'h000400);
      applyStimulus(4'b0001, 4'b0001, 24, 6, 2'd0, 24'h000200, 12, 2'd0, 24'h000400, 0, 0, 0);
      checkOutput("divider change pulses", bitsOf(0, 24, 1'b0),
                  at(1) | at(5) | at(9) | at(11) | at(13) | at(15) | at(19) | at(23));
      checkOutput("divider change pending", bitsOf(0, 24, 1'b1), at(7) | at(8) | at(13) | at(14));

      // Enable gap of 5 cycles in a div-3 period.
      writeDiv(2'd0, 24'h000300);
      applyStimulus(4'b0001, 4'b0001, 20, -1, 2'd0, 24'h0, -1, 2'd0, 24'h0, 0, 5, 5);
      checkOutput("enable gap pulses", bitsOf(0, 20, 1'b0),
                  at(1) | at(4) | at(12) | at(15) | at(18));

      // Two div-3 channels out of phase, then restarted together.
      writeDiv(2'd1, 24'h000300);
      applyStimulus(4'b0001, 4'b0001, 1, -1, 2'd0, 24'h0, -1, 2'd0, 24'h0, 0, 0, 0);
      applyStimulus(4'b0010, 4'b0011, 4, -1, 2'd0, 24'h0, -1, 2'd0, 24'h0, 0, 0, 0);
      checkOutput("out of phase ch0", bitsOf(0, 4, 1'b0), at(0) | at(3));
      checkOutput("out of phase ch1", bitsOf(1, 4, 1'b0), at(1));
      applyStimulus(4'b0011, 4'b0011, 12, -1, 2'd0, 24'h0, -1, 2'd0, 24'h0, 0, 0, 0);
      checkOutput("aligned ch0", bitsOf(0, 12, 1'b0), at(1) | at(4) | at(7) | at(10));
      checkOutput("aligned ch1", bitsOf(1, 12, 1'b0), at(1) | at(4) | at(7) | at(10));

      // Reset mid-run returns the divider to 1.0.
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid-run reset pen", 64'(pen), 64'h0);
      reset = 1'b0; en = 4'b0001;
      @(negedge clk);
      checkOutput("post reset pen 1", 64'(pen), 64'h1);
      @(negedge clk);
      checkOutput("post reset pen 2", 64'(pen), 64'h1);

      // Divider 0 means 65536 cycles per pulse.
      writeDiv(2'd2, 24'h000000);
      restart = 4'b0100; en = 4'b0100;
      pulseCount = 0;
      secondAt   = -1;
      for (int k = 0; k < 65540; k++) begin
         @(negedge clk);
         restart = '0;
         if (pen[2]) begin
            if (pulseCount == 1) secondAt = k;
            pulseCount++;
         end
      end
      checkOutput("div65536 pulse count", 64'(pulseCount), 64'd2);
      checkOutput("div65536 second pulse", 64'(secondAt), 64'd65537);

      en = '0;
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
